// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequenced ALU controller: FSM states, command and ALU op codes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [3:0] CMD_MUL = 4'b1000;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic cmd_illegal(input logic [3:0] cmd);
    return cmd[3] && (cmd != CMD_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_mul_regs.sv
// Shift-and-add multiply state: accumulator, multiplicand, multiplier and iteration count.
module alu_seq_mul_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             iter_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] alu_z_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] acc_nxt_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      count_d  = '0;
    end else if (iter_i) begin
      if (mplier_q[0]) acc_d = alu_z_i;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign acc_o     = acc_q;
  assign mcand_o   = mcand_q;
  assign acc_nxt_o = acc_d;
  assign last_o    = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around an external yAlu: single ops in one EXEC cycle, MUL as 32 add/shift steps.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_z,
  output logic             res_zero,
  output logic             res_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_z_q, res_z_d;
  logic             res_zero_q, res_zero_d, res_err_q, res_err_d;
  logic             mul_load, mul_iter, mul_last;
  logic [WIDTH-1:0] acc, mcand, acc_nxt;

  alu_seq_mul_regs #(.WIDTH(WIDTH)) u_mul_regs (
    .clk      (clk),
    .rst      (rst),
    .load_i   (mul_load),
    .iter_i   (mul_iter),
    .a_i      (req_a),
    .b_i      (req_b),
    .alu_z_i  (alu_z),
    .acc_o    (acc),
    .mcand_o  (mcand),
    .acc_nxt_o(acc_nxt),
    .last_o   (mul_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    res_z_d    = res_z_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    mul_load   = 1'b0;
    mul_iter   = 1'b0;
    req_ready  = 1'b0;
    res_valid  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = OP_AND;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d = req_cmd;
          a_d   = req_a;
          b_d   = req_b;
          if (req_cmd == CMD_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        // Illegal commands never reach the ALU; they report a zero result with the error flag.
        if (cmd_illegal(cmd_q)) begin
          res_z_d    = '0;
          res_zero_d = 1'b1;
          res_err_d  = 1'b1;
        end else begin
          alu_a      = a_q;
          alu_b      = b_q;
          alu_op     = cmd_q[2:0];
          res_z_d    = alu_z;
          res_zero_d = alu_zero;
          res_err_d  = 1'b0;
        end
        state_d = DONE;
      end
      MUL: begin
        alu_a    = acc;
        alu_b    = mcand;
        alu_op   = OP_ADD;
        mul_iter = 1'b1;
        if (mul_last) begin
          res_z_d    = acc_nxt;
          res_zero_d = (acc_nxt == '0);
          res_err_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_z_q    <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_z_q    <= res_z_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
    end
  end

  assign res_z    = res_z_q;
  assign res_zero = res_zero_q;
  assign res_err  = res_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural yAlu, expected results queued at issue and checked at delivery.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        res_valid, res_ready;
  logic [31:0] res_z;
  logic        res_zero, res_err, busy;

  typedef struct {
    logic [31:0] z;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
    .res_zero(res_zero), .res_err(res_err), .busy(busy)
  );

  always_comb begin
    alu_z = 32'h0;
    case (alu_op)
      3'b000: alu_z = alu_a & alu_b;
      3'b001: alu_z = alu_a | alu_b;
      3'b010: alu_z = alu_a + alu_b;
      3'b110: alu_z = alu_a - alu_b;
      3'b111: alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'h1 : 32'h0;
      default: alu_z = 32'h0;
    endcase
    alu_zero = (alu_z == 32'h0);
  end

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.err = 1'b0;
    e.z   = 32'h0;
    if (c == 4'b1000) begin
      p   = {32'h0, a} * {32'h0, b};
      e.z = p[31:0];
    end else if (c[3]) begin
      e.err = 1'b1;
    end else begin
      case (c[2:0])
        3'b000: e.z = a & b;
        3'b001: e.z = a | b;
        3'b010: e.z = a + b;
        3'b110: e.z = a - b;
        3'b111: e.z = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        default: e.z = 32'h0;
      endcase
    end
    e.zero = (e.z == 32'h0);
    return e;
  endfunction

  // Present a command for one cycle; returns just after the accepting edge with junk on the inputs.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL send_idle: ready=%b busy=%b want ready=1 busy=0", req_ready, busy);
    else passed++;
    req_valid = 1'b1;
    req_cmd   = c;
    req_a     = a;
    req_b     = b;
    sb.push_back(model(c, a, b));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 4'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
  endtask

  task automatic get_result(input int exp_lat, input string nm);
    exp_t e;
    int   lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (res_valid !== 1'b1 && lat < 200);
    e = sb.pop_front();
    checks++;
    if (lat != exp_lat) $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat);
    else passed++;
    checks++;
    if (res_z !== e.z) $display("FAIL %s_z: got %h want %h", nm, res_z, e.z);
    else passed++;
    checks++;
    if (res_zero !== e.zero) $display("FAIL %s_zero: got %b want %b", nm, res_zero, e.zero);
    else passed++;
    checks++;
    if (res_err !== e.err) $display("FAIL %s_err: got %b want %b", nm, res_err, e.err);
    else passed++;
    checks++;
    if (alu_op !== 3'b000 || alu_a !== 32'h0 || alu_b !== 32'h0)
      $display("FAIL %s_done_alu: got op=%b a=%h b=%h want 0", nm, alu_op, alu_a, alu_b);
    else passed++;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ack_idle: valid=%b busy=%b want 0 0", res_valid, busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_cmd = 4'h0; req_a = 32'h0; req_b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctl: ready=%b valid=%b busy=%b want 1 0 0", req_ready, res_valid, busy);
    else passed++;
    checks++;
    if (alu_op !== 3'b000 || res_z !== 32'h0 || res_zero !== 1'b0 || res_err !== 1'b0)
      $display("FAIL reset_data: op=%b z=%h zero=%b err=%b want 0", alu_op, res_z, res_zero, res_err);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single_ops();
    logic [3:0]  cmds[7] = '{4'b0010, 4'b0110, 4'b1011, 4'b0111, 4'b0111, 4'b0000, 4'b0001};
    logic [31:0] as[7]   = '{32'd5, 32'd9, 32'd3, 32'hFFFFFFFF, 32'd4, 32'h0, 32'h0};
    logic [31:0] bs[7]   = '{32'd7, 32'd9, 32'd4, 32'd1, 32'hFFFFFFF0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      if (i >= 5) begin
        as[i] = $urandom;
        bs[i] = $urandom;
      end
      send(cmds[i], as[i], bs[i]);
      get_result(2, $sformatf("op%0d", i));
      ack();
    end
  endtask

  task automatic test_mul();
    logic [31:0] as[4] = '{32'h00001234, 32'hFFFFFFFF, 32'h00010000, 32'h0};
    logic [31:0] bs[4] = '{32'h00000010, 32'h00000002, 32'h00010000, 32'h0};
    as[3] = $urandom;
    bs[3] = $urandom;
    for (int i = 0; i < 4; i++) begin
      send(4'b1000, as[i], bs[i]);
      get_result(33, $sformatf("mul%0d", i));
      ack();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    send(4'b0010, 32'd100, 32'd23);
    get_result(2, "bp");
    held = res_z;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_cmd   = 4'b0010;
      req_a     = 32'd3;
      req_b     = 32'd4;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_z !== held || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d: valid=%b z=%h ready=%b want 1 %h 0", i, res_valid, res_z, req_ready, held);
      else passed++;
    end
    req_valid = 1'b0;
    ack();
    send(4'b0010, 32'd3, 32'd4);
    get_result(2, "b2b");
    ack();
  endtask

  task automatic test_reset_mid_mul();
    send(4'b1000, 32'h0000ABCD, 32'h00001111);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_op !== 3'b010)
      $display("FAIL mid_mul: busy=%b op=%b want 1 010", busy, alu_op);
    else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_front());
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1 || res_z !== 32'h0)
      $display("FAIL abort: busy=%b valid=%b ready=%b z=%h want 0 0 1 0", busy, res_valid, req_ready, res_z);
    else passed++;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) $display("FAIL abort_noresult: valid=%b want 0", res_valid);
      else passed++;
    end
    send(4'b0010, 32'd1, 32'd1);
    get_result(2, "post_abort");
    ack();
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: datapath width, fixed at 32 for this release.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  command present.
REQ-005 req_ready  output  1  controller can accept a command.
REQ-006 req_cmd  input  4  0xxx = single ALU op with op = cmd[2:0]; 1000 = MUL; other 1xxx = illegal.
REQ-007 req_a, req_b  input  32 each  operands.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the external yAlu.
REQ-009 alu_op  output  3  op driven to yAlu: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-010 alu_z  input  32  yAlu result.
REQ-011 alu_zero  input  1  yAlu zero flag.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_z  output  32  result.
REQ-015 res_zero  output  1  result == 0.
REQ-016 res_err  output  1  illegal command flag.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 The state machine SHALL have states IDLE, EXEC, MUL and DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with req_valid & req_ready.
REQ-020 On acceptance, req_cmd, req_a and req_b SHALL be registered; input changes after acceptance are ignored.
REQ-021 Accepted cmd 0xxx SHALL transition IDLE->EXEC.
- In EXEC: alu_a = A, alu_b = B, alu_op = cmd[2:0].
- alu_z and alu_zero are captured into res_z and res_zero.
- Next state is DONE; res_valid rises 2 cycles after acceptance.
REQ-022 Accepted cmd 1000 SHALL transition IDLE->MUL with acc = 0, mcand = A, mplier = B and the 5-bit count = 0.
REQ-023 Each MUL cycle SHALL:
- drive alu_a = acc, alu_b = mcand, alu_op = 010;
- load acc <= alu_z if mplier[0] = 1, otherwise hold acc;
- shift mcand left by 1 and mplier right by 1 (logical);
- increment count.
REQ-024 MUL SHALL run exactly 32 cycles with no early exit, then enter DONE.
- res_z = low 32 bits of the unsigned product (carry-out discarded, wrap-around modulo 2^32).
- res_zero = (res_z == 0).
- res_valid rises 33 cycles after acceptance.
REQ-025 An accepted illegal cmd (1001..1111) SHALL go IDLE->EXEC->DONE with res_z = 0, res_zero = 1, res_err = 1 and alu_op = 000 in EXEC.
- res_err SHALL be 0 for all legal commands.
REQ-026 In DONE, res_valid = 1, and res_z, res_zero and res_err SHALL hold stable until res_ready = 1.
- DONE & res_ready SHALL return to IDLE on the next cycle; res_valid deasserts in that cycle.
REQ-027 No new command SHALL be accepted in the same cycle as a result handshake; the earliest next acceptance is the first IDLE cycle.
REQ-028 In IDLE and DONE, alu_a = alu_b = 0 and alu_op = 000.
REQ-029 The design SHALL hold no combinational path from alu_z to res_z; results are registered.

Reset
REQ-030 While rst = 1 at a clock edge, the next state SHALL be IDLE, with res_valid = 0, res_z = 0, res_zero = 0, res_err = 0, busy = 0, count = 0, acc = 0 and req_ready = 1.
REQ-031 A reset asserted in EXEC, MUL or DONE SHALL abort the operation; no result is delivered.
REQ-032 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-033 A shared package/header alu_seq_pkg SHALL hold:
- state encodings: IDLE = 2'b00, EXEC = 2'b01, MUL = 2'b10, DONE = 2'b11;
- the CMD_MUL = 4'b1000 constant;
- the ALU op constants AND/OR/ADD/SUB/SLT.
REQ-034 One sub-module, alu_seq_mul_regs (acc/mcand/mplier/count registers with load, shift and iterate controls), SHALL be instantiated; the yAlu instance SHALL stay outside, in the parent.

Verification
REQ-035 Reset: rst = 1 for 2 cycles -> req_ready = 1, res_valid = 0, busy = 0, alu_op = 000, res_z = 0.
REQ-036 ADD: cmd 0010, A = 5, B = 7 -> res_valid exactly 2 cycles after acceptance, res_z = 12, res_zero = 0, res_err = 0.
REQ-037 SUB: cmd 0110, A = 9, B = 9 -> res_z = 0, res_zero = 1; illegal cmd 1011 -> res_z = 0, res_err = 1 after 2 cycles.
REQ-038 MUL, each result arriving exactly 33 cycles after acceptance:
- A = 0x00001234, B = 0x00000010 -> res_z = 0x00012340;
- A = 0xFFFFFFFF, B = 2 -> res_z = 0xFFFFFFFE (wrap);
- A = 0x10000, B = 0x10000 -> res_z = 0, res_zero = 1.
REQ-039 Backpressure: hold res_ready = 0 for 5 cycles in DONE -> res_z stable, req_ready = 0, new req_valid ignored; the next command is accepted 1 cycle after the handshake.
REQ-040 Reset mid-MUL: rst = 1 at iteration 10 -> next cycle state IDLE, busy = 0, res_valid = 0; a following ADD 1+1 returns 2.
